// File: rtl/vote_tally_if.sv
// Bus bundle for vote_tally: poll control and button inputs in, tallies and status pulses out.
interface vote_tally_if #(
  parameter int unsigned CNT_W = 29
);
  logic             poll_open;
  logic             vote_A;
  logic             vote_B;
  logic [1:0]       state_sel;
  logic [CNT_W-1:0] counter_A;
  logic [CNT_W-1:0] counter_B;
  logic [CNT_W-1:0] counter_DC_A;
  logic [CNT_W-1:0] counter_DC_B;
  logic [CNT_W-1:0] counter_MD_A;
  logic [CNT_W-1:0] counter_MD_B;
  logic [CNT_W-1:0] counter_VA_A;
  logic [CNT_W-1:0] counter_VA_B;
  logic             vote_ack;
  logic             vote_reject;
  logic             busy;

  modport master (
    output poll_open, vote_A, vote_B, state_sel,
    input  counter_A, counter_B, counter_DC_A, counter_DC_B,
           counter_MD_A, counter_MD_B, counter_VA_A, counter_VA_B,
           vote_ack, vote_reject, busy
  );

  modport slave (
    input  poll_open, vote_A, vote_B, state_sel,
    output counter_A, counter_B, counter_DC_A, counter_DC_B,
           counter_MD_A, counter_MD_B, counter_VA_A, counter_VA_B,
           vote_ack, vote_reject, busy
  );
endinterface

// File: rtl/vote_tally.sv
// Vote capture: sync + debounce of two buttons, qualification, saturating per-state/national tallies.
// Define VOTE_TALLY_CLEAR_EN to add the clear_counts input (clears tallies while idle with poll closed).
module vote_tally #(
  parameter int unsigned CNT_W           = 29,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
`ifdef VOTE_TALLY_CLEAR_EN
  input logic         clear_counts,
`endif
  vote_tally_if.slave bus
);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_CAST, S_LOCKOUT} state_t;

  state_t           r_state;
  logic [1:0]       r_sync_a;
  logic [1:0]       r_sync_b;
  logic [1:0]       r_cap;
  logic [DB_W-1:0]  r_cnt;
  logic [CNT_W-1:0] r_nat_a, r_nat_b;
  logic [CNT_W-1:0] r_dc_a, r_dc_b, r_md_a, r_md_b, r_va_a, r_va_b;
  logic             r_ack, r_rej, r_busy;
  logic [1:0]       w_pat;

  assign w_pat = {r_sync_a[1], r_sync_b[1]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_cap    <= '0;
      r_cnt    <= '0;
      r_nat_a  <= '0;
      r_nat_b  <= '0;
      r_dc_a   <= '0;
      r_dc_b   <= '0;
      r_md_a   <= '0;
      r_md_b   <= '0;
      r_va_a   <= '0;
      r_va_b   <= '0;
      r_ack    <= 1'b0;
      r_rej    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[0], bus.vote_A};
      r_sync_b <= {r_sync_b[0], bus.vote_B};
      r_ack    <= 1'b0;
      r_rej    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.poll_open && (w_pat != 2'b00)) begin
            r_cap   <= w_pat;
            r_cnt   <= DB_W'(1);
            r_state <= S_DEBOUNCE;
            r_busy  <= 1'b1;
          end
`ifdef VOTE_TALLY_CLEAR_EN
          if (clear_counts && !bus.poll_open) begin
            r_nat_a <= '0;
            r_nat_b <= '0;
            r_dc_a  <= '0;
            r_dc_b  <= '0;
            r_md_a  <= '0;
            r_md_b  <= '0;
            r_va_a  <= '0;
            r_va_b  <= '0;
          end
`endif
        end
        S_DEBOUNCE: begin
          if (!bus.poll_open || (w_pat != r_cap)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
            r_state <= S_CAST;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        S_CAST: begin
          // r_cap is {A,B} and never 00 here, so cap[1] alone picks the candidate.
          if ((r_cap == 2'b11) || (bus.state_sel == 2'b11)) begin
            r_rej <= 1'b1;
          end else begin
            r_ack <= 1'b1;
            case (bus.state_sel)
              2'b00:   if (r_cap[1]) r_dc_a <= sat_inc(r_dc_a); else r_dc_b <= sat_inc(r_dc_b);
              2'b01:   if (r_cap[1]) r_md_a <= sat_inc(r_md_a); else r_md_b <= sat_inc(r_md_b);
              2'b10:   if (r_cap[1]) r_va_a <= sat_inc(r_va_a); else r_va_b <= sat_inc(r_va_b);
              default: ;
            endcase
            if (r_cap[1]) r_nat_a <= sat_inc(r_nat_a);
            else          r_nat_b <= sat_inc(r_nat_b);
          end
          r_cnt   <= '0;
          r_state <= S_LOCKOUT;
        end
        S_LOCKOUT: begin
          if (w_pat != 2'b00) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.counter_A    = r_nat_a;
  assign bus.counter_B    = r_nat_b;
  assign bus.counter_DC_A = r_dc_a;
  assign bus.counter_DC_B = r_dc_b;
  assign bus.counter_MD_A = r_md_a;
  assign bus.counter_MD_B = r_md_b;
  assign bus.counter_VA_A = r_va_a;
  assign bus.counter_VA_B = r_va_b;
  assign bus.vote_ack     = r_ack;
  assign bus.vote_reject  = r_rej;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_vote_tally.sv
// Directed self-checking bench for vote_tally (CNT_W=3, DEBOUNCE_CYCLES=4).
module tb_vote_tally;
  localparam int unsigned CW = 3;
  localparam int unsigned DB = 4;

  logic clk;
  logic rst;
`ifdef VOTE_TALLY_CLEAR_EN
  logic clear_counts;
`endif
  int unsigned n_checks;
  int unsigned n_pass;

  vote_tally_if #(.CNT_W(CW)) bus ();

  vote_tally #(.CNT_W(CW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef VOTE_TALLY_CLEAR_EN
    .clear_counts (clear_counts),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  // Hold the given buttons for 'hold' cycles counting pulses, then release and wait for IDLE.
  task automatic press(input logic a, input logic b, input int unsigned hold,
                       output int unsigned acks, output int unsigned rejs);
    acks = 0;
    rejs = 0;
    bus.vote_A = a;
    bus.vote_B = b;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.vote_ack) acks++;
      if (bus.vote_reject) rejs++;
    end
    bus.vote_A = 1'b0;
    bus.vote_B = 1'b0;
    wait_idle("release_idle");
  endtask

  initial begin
    int unsigned acks, rejs, tot;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.poll_open = 1'b0;
    bus.vote_A    = 1'b0;
    bus.vote_B    = 1'b0;
    bus.state_sel = 2'b00;
`ifdef VOTE_TALLY_CLEAR_EN
    clear_counts = 1'b0;
`endif
    step(3);
    rst = 1'b0;
    chk("rst_A",    32'(bus.counter_A),    32'd0);
    chk("rst_B",    32'(bus.counter_B),    32'd0);
    chk("rst_MD_A", 32'(bus.counter_MD_A), 32'd0);
    chk("rst_ack",  32'(bus.vote_ack),     32'd0);
    chk("rst_rej",  32'(bus.vote_reject),  32'd0);
    chk("rst_busy", 32'(bus.busy),         32'd0);

    // Single MD-A vote: press seen at edge 0, counted at edge 7.
    bus.poll_open = 1'b1;
    bus.state_sel = 2'b01;
    bus.vote_A    = 1'b1;
    step(2);
    chk("v1_busy_e1", 32'(bus.busy), 32'd0);
    step(1);
    chk("v1_busy_e2", 32'(bus.busy), 32'd1);
    step(4);
    chk("v1_ack_e6",  32'(bus.vote_ack),     32'd0);
    chk("v1_MDA_e6",  32'(bus.counter_MD_A), 32'd0);
    step(1);
    chk("v1_ack_e7",  32'(bus.vote_ack),     32'd1);
    chk("v1_MDA_e7",  32'(bus.counter_MD_A), 32'd1);
    chk("v1_A_e7",    32'(bus.counter_A),    32'd1);
    acks = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.vote_ack || bus.vote_reject) acks++;
    end
    chk("v1_no_repeat", acks, 32'd0);
    chk("v1_MDA_hold",  32'(bus.counter_MD_A), 32'd1);
    chk("v1_DCA",       32'(bus.counter_DC_A), 32'd0);
    chk("v1_VAA",       32'(bus.counter_VA_A), 32'd0);
    chk("v1_B",         32'(bus.counter_B),    32'd0);
    bus.vote_A = 1'b0;
    wait_idle("v1_idle");

    // Bounce on B: 2-cycle toggles never debounce; the final hold counts once.
    bus.state_sel = 2'b10;
    tot = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      bus.vote_B = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (bus.vote_ack || bus.vote_reject) tot++;
    end
    chk("bnc_no_pulse", tot, 32'd0);
    press(1'b0, 1'b1, 10, acks, rejs);
    chk("bnc_ack",  acks, 32'd1);
    chk("bnc_rej",  rejs, 32'd0);
    chk("bnc_VAB",  32'(bus.counter_VA_B), 32'd1);
    chk("bnc_B",    32'(bus.counter_B),    32'd1);
    chk("bnc_A",    32'(bus.counter_A),    32'd1);

    // Both buttons, then invalid state: rejected, no counter moves.
    bus.state_sel = 2'b00;
    press(1'b1, 1'b1, 10, acks, rejs);
    chk("both_rej", rejs, 32'd1);
    chk("both_ack", acks, 32'd0);
    chk("both_A",   32'(bus.counter_A),    32'd1);
    chk("both_B",   32'(bus.counter_B),    32'd1);
    chk("both_DCA", 32'(bus.counter_DC_A), 32'd0);
    bus.state_sel = 2'b11;
    press(1'b1, 1'b0, 10, acks, rejs);
    chk("inv_rej", rejs, 32'd1);
    chk("inv_ack", acks, 32'd0);
    chk("inv_A",   32'(bus.counter_A), 32'd1);

    // Poll closed at DEBOUNCE cycle 4.
    bus.state_sel = 2'b01;
    bus.vote_A    = 1'b1;
    step(5);
    chk("abt_busy_hi", 32'(bus.busy), 32'd1);
    bus.poll_open = 1'b0;
    step(1);
    chk("abt_busy_lo", 32'(bus.busy), 32'd0);
    tot = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.vote_ack || bus.vote_reject || bus.busy) tot++;
    end
    chk("abt_quiet", tot, 32'd0);
    chk("abt_A",     32'(bus.counter_A),    32'd1);
    chk("abt_MDA",   32'(bus.counter_MD_A), 32'd1);
    bus.vote_A    = 1'b0;
    bus.poll_open = 1'b1;
    step(3);

    // Reset while in CAST discards the vote and clears everything.
    bus.vote_A = 1'b1;
    step(7);
    chk("cst_busy", 32'(bus.busy),         32'd1);
    chk("cst_MDA",  32'(bus.counter_MD_A), 32'd1);
    rst = 1'b1;
    step(1);
    chk("cst_rst_A",    32'(bus.counter_A),    32'd0);
    chk("cst_rst_B",    32'(bus.counter_B),    32'd0);
    chk("cst_rst_MDA",  32'(bus.counter_MD_A), 32'd0);
    chk("cst_rst_VAB",  32'(bus.counter_VA_B), 32'd0);
    chk("cst_rst_ack",  32'(bus.vote_ack),     32'd0);
    chk("cst_rst_busy", 32'(bus.busy),         32'd0);
    rst = 1'b0;
    bus.vote_A = 1'b0;
    step(4);
    chk("cst_post_ack", 32'(bus.counter_A), 32'd0);

    // Saturation at 7 with 3-bit counters.
    bus.state_sel = 2'b00;
    tot = 0;
    for (int unsigned v = 0; v < 7; v++) begin
      press(1'b1, 1'b0, 10, acks, rejs);
      tot += acks;
    end
    chk("sat_acks7", tot, 32'd7);
    chk("sat_DCA7",  32'(bus.counter_DC_A), 32'd7);
    chk("sat_A7",    32'(bus.counter_A),    32'd7);
    press(1'b1, 1'b0, 10, acks, rejs);
    chk("sat_ack8",  acks, 32'd1);
    chk("sat_DCA8",  32'(bus.counter_DC_A), 32'd7);
    chk("sat_A8",    32'(bus.counter_A),    32'd7);
    chk("sat_B8",    32'(bus.counter_B),    32'd0);

`ifdef VOTE_TALLY_CLEAR_EN
    clear_counts = 1'b1;
    step(2);
    chk("clr_open_DCA", 32'(bus.counter_DC_A), 32'd7);
    bus.poll_open = 1'b0;
    step(1);
    chk("clr_DCA", 32'(bus.counter_DC_A), 32'd0);
    chk("clr_A",   32'(bus.counter_A),    32'd0);
    clear_counts = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
